// File: rtl/static_frame_sequencer.sv
// Sequences frozen-frame capture into the static BRAM, launches the correlator once the
// frame is complete, and arbitrates the static BRAM read port (correlator over display).
module static_frame_sequencer #(
  parameter int FRAME_W        = 640,
  parameter int FRAME_H        = 480,
  parameter int ADDR_W         = 19,
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tracking_mode,
  input  logic [ADDR_W-1:0] capture_addr,
  input  logic              corr_done,
  input  logic [ADDR_W-1:0] corr_rd_addr,
  input  logic              disp_rd_req,
  input  logic [ADDR_W-1:0] disp_rd_addr,
  output logic              static_we_en,
  output logic              corr_start,
  output logic              corr_active,
  output logic [ADDR_W-1:0] static_rd_addr,
  output logic              disp_rd_valid,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  frame_count,
  output logic              timeout_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);
  localparam int                TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SOF   = 3'd1,
    CAPTURE    = 3'd2,
    START_CORR = 3'd3,
    CORRELATE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] prev_addr_q;
  logic              corr_done_prev_q;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              static_we_en_q, static_we_en_d;
  logic              corr_start_q, corr_start_d;
  logic              corr_active_q, corr_active_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              disp_grant_q, disp_grant_d;
  logic              disp_rd_valid_q, disp_rd_valid_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic              timeout_err_q, timeout_err_d;

  logic frame_end, corr_rise, abort, done_hit, timeout_hit, corr_owns;

  assign frame_end = (capture_addr == LAST_ADDR) && (prev_addr_q != LAST_ADDR);
  assign corr_rise = corr_done && !corr_done_prev_q;
  assign abort     = !tracking_mode && (state_q != IDLE);
  assign corr_owns = (state_q == START_CORR) || (state_q == CORRELATE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      prev_addr_q      <= '0;
      corr_done_prev_q <= 1'b0;
      timer_q          <= '0;
      static_we_en_q   <= 1'b0;
      corr_start_q     <= 1'b0;
      corr_active_q    <= 1'b0;
      rd_addr_q        <= '0;
      disp_grant_q     <= 1'b0;
      disp_rd_valid_q  <= 1'b0;
      frame_count_q    <= '0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      prev_addr_q      <= capture_addr;
      corr_done_prev_q <= corr_done;
      timer_q          <= timer_d;
      static_we_en_q   <= static_we_en_d;
      corr_start_q     <= corr_start_d;
      corr_active_q    <= corr_active_d;
      rd_addr_q        <= rd_addr_d;
      disp_grant_q     <= disp_grant_d;
      disp_rd_valid_q  <= disp_rd_valid_d;
      frame_count_q    <= frame_count_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE:       if (tracking_mode) state_d = WAIT_SOF;
      WAIT_SOF:   if (frame_end) state_d = CAPTURE;
      CAPTURE:    if (frame_end) state_d = START_CORR;
      START_CORR: state_d = CORRELATE;
      CORRELATE: begin
        // A done pulse beats a simultaneous timeout.
        if (corr_rise) begin
          done_hit = 1'b1;
          state_d  = WAIT_SOF;
        end else if (timer_q == TMR_LAST) begin
          timeout_hit = 1'b1;
          state_d     = WAIT_SOF;
        end
      end
      default:    state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  always_comb begin
    static_we_en_d  = (state_d == CAPTURE);
    corr_start_d    = (state_d == START_CORR);
    corr_active_d   = (state_d == CORRELATE);
    timer_d         = (state_q == CORRELATE && state_d == CORRELATE) ? timer_q + 1'b1 : '0;
    frame_count_d   = frame_count_q + CNT_W'(done_hit);
    timeout_err_d   = timeout_err_q;
    if (state_q == IDLE && state_d == WAIT_SOF) timeout_err_d = 1'b0;
    else if (timeout_hit)                       timeout_err_d = 1'b1;
    rd_addr_d       = rd_addr_q;
    disp_grant_d    = 1'b0;
    if (abort) begin
      rd_addr_d = '0;
    end else if (corr_owns) begin
      rd_addr_d = corr_rd_addr;
    end else if (disp_rd_req) begin
      rd_addr_d    = disp_rd_addr;
      disp_grant_d = 1'b1;
    end
    // Valid trails the grant by one more cycle to cover the BRAM read latency.
    disp_rd_valid_d = abort ? 1'b0 : disp_grant_q;
  end

  assign static_we_en   = static_we_en_q;
  assign corr_start     = corr_start_q;
  assign corr_active    = corr_active_q;
  assign static_rd_addr = rd_addr_q;
  assign disp_rd_valid  = disp_rd_valid_q;
  assign state          = state_q;
  assign frame_count    = frame_count_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: doc/static_frame_sequencer.md
Name: static_frame_sequencer

Overview:
- Sequences the tracking pipeline around the static (frozen) frame BRAM.
- Arms a clean full-frame write into the static BRAM, starts the correlator once the frame is complete, waits for its result, then re-arms for the next frame.
- Owns the static BRAM read port and shares it between the correlator (priority) and a display/debug reader.
- Sits between ov7670_capture address/we, the static blk_mem_gen_0 instance, and the correlator; replaces ad-hoc write-enable triggering.

Parameters:
- FRAME_W, 640, pixels per line.
- FRAME_H, 480, lines per frame; LAST_ADDR = FRAME_W*FRAME_H-1.
- ADDR_W, 19, BRAM address width.
- TIMEOUT_CYCLES, 4000000, max clk cycles in CORRELATE before abort.
- CNT_W, 8, width of frame_count.

Ports:
- clk  in  1  system clock (clk_50 domain).
- reset  in  1  asynchronous, active-high reset.
- tracking_mode  in  1  level; 1 = tracking enabled.
- capture_addr  in  ADDR_W  camera write address, already sampled into clk domain.
- corr_done  in  1  correlator max_ready; single-cycle pulse or level, rising edge used.
- corr_rd_addr  in  ADDR_W  correlator static-BRAM read address.
- disp_rd_req  in  1  display/debug read request.
- disp_rd_addr  in  ADDR_W  display read address.
- static_we_en  out  1  gate ANDed with capture_we for the static BRAM.
- corr_start  out  1  one-cycle start pulse to correlator.
- corr_active  out  1  high while correlator owns the read port.
- static_rd_addr  out  ADDR_W  muxed static BRAM port-B address.
- disp_rd_valid  out  1  display data on BRAM dout is valid this cycle.
- state  out  3  encoded FSM state, for LEDs/debug.
- frame_count  out  CNT_W  completed correlations, wraps.
- timeout_err  out  1  sticky correlator-timeout flag.

Behaviour:
- Reset values: state=IDLE(0); static_we_en, corr_start, corr_active, disp_rd_valid, timeout_err = 0; frame_count = 0; static_rd_addr = 0; prev_addr = 0.
- frame_end: combinational, = (capture_addr==LAST_ADDR) && (prev_addr!=LAST_ADDR). prev_addr is registered every cycle.
- States: IDLE=0, WAIT_SOF=1, CAPTURE=2, START_CORR=3, CORRELATE=4.
- IDLE:
  - tracking_mode=1 -> WAIT_SOF.
  - Entering WAIT_SOF from IDLE clears timeout_err.
- WAIT_SOF: frame_end -> CAPTURE. This guarantees the write starts at address 0.
- CAPTURE:
  - static_we_en=1 (registered; high in every cycle that state==CAPTURE).
  - frame_end -> START_CORR; static_we_en drops the following cycle.
- START_CORR: corr_start=1 for exactly one cycle -> CORRELATE.
- CORRELATE:
  - corr_active=1; timeout counter increments from 0.
  - Rising edge of corr_done -> frame_count+1 (wraps at 2^CNT_W) -> WAIT_SOF.
  - Counter reaching TIMEOUT_CYCLES-1 -> timeout_err=1 -> WAIT_SOF; frame_count unchanged.
  - corr_done and timeout in the same cycle: done wins.
- Abort:
  - tracking_mode=0 in any non-IDLE state -> IDLE next cycle; all outputs except frame_count/timeout_err return to reset values that cycle.
  - Abort takes priority over every other transition.
- Arbitration:
  - static_rd_addr = corr_rd_addr when state is START_CORR or CORRELATE.
  - Otherwise static_rd_addr = disp_rd_addr if disp_rd_req, else hold the previous value. Registered, 1-cycle latency.
  - disp_rd_valid = 1 exactly 2 cycles after a granted disp_rd_req (1 cycle address register + 1 cycle BRAM).
  - A request denied because the correlator owns the port produces no valid; requesters retry.
- corr_done rising edge outside CORRELATE is ignored.
- frame_end during START_CORR/CORRELATE is ignored; no overlapping capture.
- Async reset mid-frame: immediate return to IDLE; the next capture waits for a fresh frame_end.

Test Plan (FRAME_W=4, FRAME_H=2 so LAST_ADDR=7, TIMEOUT_CYCLES=20):
- Reset, tracking_mode=1, capture_addr cycles 0..7 twice -> WAIT_SOF until first addr=7; static_we_en high from the following cycle through the second addr=7; corr_start single pulse one cycle later.
- In CORRELATE, pulse corr_done after 5 cycles -> frame_count 0->1, state back to WAIT_SOF, corr_active low next cycle.
- In CORRELATE, withhold corr_done -> after 20 cycles timeout_err=1, state=WAIT_SOF, frame_count unchanged; tracking_mode 0 then 1 clears timeout_err.
- Drop tracking_mode mid-CAPTURE (capture_addr=3) -> static_we_en=0 and state=IDLE next cycle; re-enable -> waits for next addr=7 before writing.
- disp_rd_req with disp_rd_addr=5 in IDLE -> static_rd_addr=5 next cycle, disp_rd_valid 2 cycles after the request; the same request during CORRELATE -> static_rd_addr follows corr_rd_addr, no disp_rd_valid.
- Hold capture_addr=7 for 10 cycles -> exactly one frame_end; frame_count 255 + corr_done -> wraps to 0.
